// File: rtl/mmm_res_reduce.sv
// mmm_res_reduce: reduces an unreduced Montgomery result into [0, p) by bounded repeated subtraction.
// Defining MMM_RED_ERR_EN adds the o_err port, which flags reductions that hit MAXIT or have p == 0.
module mmm_res_reduce #(
  parameter int IDW   = 256,
  parameter int ODW   = IDW + 3,
  parameter int MAXIT = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [ODW-1:0] i_res,
  input  logic [IDW-1:0] i_p,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [IDW-1:0] o_res
`ifdef MMM_RED_ERR_EN
  ,
  output logic           o_err
`endif
);
  localparam int CW = $clog2(MAXIT + 1);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t         state;
  logic [ODW-1:0] acc, preg;
  logic [CW-1:0]  cnt;
  logic           arm;
  logic           ge;
  assign ge      = acc >= preg;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
`ifdef MMM_RED_ERR_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) o_err <= 1'b0;
    else if (state == SUB && arm && (!ge || preg == '0 || cnt == CW'(MAXIT))) o_err <= ge;
    else if (state == DONE && i_ready) o_err <= 1'b0;
`endif
  // The first SUB cycle only arms the loop, giving a fixed two-cycle minimum latency.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      preg  <= '0;
      cnt   <= '0;
      arm   <= 1'b0;
      o_res <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          acc   <= i_res;
          preg  <= ODW'(i_p);
          cnt   <= '0;
          arm   <= 1'b0;
          state <= SUB;
        end
        SUB: if (!arm) arm <= 1'b1;
        else if (!ge || preg == '0 || cnt == CW'(MAXIT)) begin
          o_res <= acc[IDW-1:0];
          state <= DONE;
        end else begin
          acc <= acc - preg;
          cnt <= cnt + 1'b1;
        end
        DONE: if (i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
